imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: accepts a byte stream (valid/ready) and assembles little-endian 32-bit instructions.
- Writes the assembled instructions sequentially into the instruction memory write port.
- Holds the CPU core in reset until a complete program image has been loaded.
- Sits between the board-level byte source (UART receiver or testbench) and the CPU/instruction memory.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_loader_word_packer.sv | 35 +++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Holds the FSM state encoding and the byte/word geometry of the stream.
package imem_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned INSTR_W        = 32;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
// The master modport is the loader side; the slave modport is the byte source and memory.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
);

   logic                byte_valid;
   logic [BYTE_W-1:0]   byte_data;
   logic                byte_ready;
   logic                imem_we;
   logic [ADDR_W-1:0]   imem_waddr;
   logic [INSTR_W-1:0]  imem_wdata;

   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_we,
      output imem_waddr,
      output imem_wdata
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_we,
      input  imem_waddr,
      input  imem_wdata
   );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer: first byte lands in [7:0], fourth in [31:24].
// word_c already includes the byte being strobed, so the caller can latch it on the filling edge.
module imem_loader_word_packer
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               strobe,
   input  logic [BYTE_W-1:0]  data,
   output logic [INSTR_W-1:0] word_c,
   output logic               word_full_c
);

   logic [INSTR_W-1:0] word;
   logic [IDX_W-1:0]   idx;

   assign word_c      = {data, word[INSTR_W-1:BYTE_W]};
   assign word_full_c = strobe && (idx == IDX_W'(BYTES_PER_WORD - 1));

   // Shift register and byte index; the index wraps on its own after each word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         idx  <= '0;
      end else if (clr) begin
         word <= '0;
         idx  <= '0;
      end else if (strobe) begin
         word <= word_c;
         idx  <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory
// and holds the CPU in reset until the whole image has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   imem_loader_if.master     bus,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_loaded
);

   localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(1) << ADDR_W;

   state_t              state, state_n;
   logic [BYTE_W-1:0]   len_lo, len_lo_n;
   logic [LEN_W-1:0]    len, len_n;
   logic [ADDR_W-1:0]   addr, addr_n;
   logic [LEN_W-1:0]    wl_n;
   logic                we_n;
   logic [ADDR_W-1:0]   waddr_n;
   logic [INSTR_W-1:0]  wdata_n;
   logic                pack_clr_c;
   logic                accept_c;
   logic                pack_strobe_c;
   logic [LEN_W-1:0]    hdr_c;
   logic [INSTR_W-1:0]  word_c;
   logic                word_full_c;

   assign accept_c      = bus.byte_valid && bus.byte_ready;
   assign pack_strobe_c = accept_c && (state == DATA);
   assign hdr_c         = LEN_W'({bus.byte_data, len_lo});

   imem_loader_word_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clr         (pack_clr_c),
      .strobe      (pack_strobe_c),
      .data        (bus.byte_data),
      .word_c      (word_c),
      .word_full_c (word_full_c)
   );

   // Next-state, datapath and next-output decode
   always_comb begin
      state_n    = state;
      len_lo_n   = len_lo;
      len_n      = len;
      addr_n     = addr;
      wl_n       = words_loaded;
      we_n       = 1'b0;
      waddr_n    = bus.imem_waddr;
      wdata_n    = bus.imem_wdata;
      pack_clr_c = 1'b0;
      case (state)
         IDLE: if (start) state_n = LEN_LO;
         LEN_LO: begin
            if (accept_c) begin
               len_lo_n = bus.byte_data;
               state_n  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept_c) begin
               len_n      = hdr_c;
               addr_n     = '0;
               wl_n       = '0;
               pack_clr_c = 1'b1;
               if (hdr_c == '0)                         state_n = DONE;
               else if ((LEN_W + 1)'(hdr_c) > DEPTH)    state_n = ERR;
               else                                     state_n = DATA;
            end
         end
         DATA: begin
            if (word_full_c) begin
               we_n    = 1'b1;
               waddr_n = addr;
               wdata_n = word_c;
               state_n = WRITE;
            end
         end
         WRITE: begin
            addr_n  = addr + ADDR_W'(1);
            wl_n    = words_loaded + LEN_W'(1);
            state_n = (wl_n == len) ? DONE : DATA;
         end
         DONE, ERR: if (start) state_n = LEN_LO;
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and outputs, all registered from the next-state decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         len_lo         <= '0;
         len            <= '0;
         addr           <= '0;
         words_loaded   <= '0;
         bus.byte_ready <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         cpu_rst_n      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         state          <= state_n;
         len_lo         <= len_lo_n;
         len            <= len_n;
         addr           <= addr_n;
         words_loaded   <= wl_n;
         bus.byte_ready <= (state_n == LEN_LO) || (state_n == LEN_HI) || (state_n == DATA);
         bus.imem_we    <= we_n;
         bus.imem_waddr <= waddr_n;
         bus.imem_wdata <= wdata_n;
         cpu_rst_n      <= (state_n == DONE);
         busy           <= (state_n == LEN_LO) || (state_n == LEN_HI) ||
                           (state_n == DATA)   || (state_n == WRITE);
         done           <= (state_n == DONE);
         err            <= (state_n == ERR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, back-pressure, length limits,
// mid-load reset and reload, checked against hand-computed writes.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned LEN_W  = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             cpu_rst_n, busy, done, err;
   logic [LEN_W-1:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   logic [31:0]       mem [256];

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .cpu_rst_n    (cpu_rst_n),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Write monitor: imem_we is a one-cycle registered pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.imem_we) begin
         wr_addr_q.push_back(bus.imem_waddr);
         wr_data_q.push_back(bus.imem_wdata);
         mem[bus.imem_waddr] = bus.imem_wdata;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!bus.byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("send_timeout", 1, 0);
         bus.byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge clk);
      while (!done && !err && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check(tag, 0, 1);
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int bad;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      // Reset then idle
      repeat (3) @(negedge clk);
      check("rst_cpu_rst_n", cpu_rst_n, 0);
      check("rst_ready", bus.byte_ready, 0);
      check("rst_we", bus.imem_we, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_cpu_rst_n", cpu_rst_n, 0);
      check("idle_ready", bus.byte_ready, 0);
      check("idle_busy", busy, 0);

      // Two-word load at full byte rate
      clear_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h00500293);
      send_word(32'h00100313);
      wait_done("two_timeout");
      check("two_nwr", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
         check("two_a0", wr_addr_q[0], 0);
         check("two_d0", wr_data_q[0], 32'h00500293);
         check("two_a1", wr_addr_q[1], 1);
         check("two_d1", wr_data_q[1], 32'h00100313);
      end
      check("two_done", done, 1);
      check("two_cpu_rst_n", cpu_rst_n, 1);
      check("two_wl", words_loaded, 2);

      // Same image with gaps between bytes and a stray start mid-load
      clear_log();
      pulse_start();
      send_byte(8'h02); @(negedge clk);
      send_byte(8'h00); @(negedge clk);
      send_byte(8'h93); @(negedge clk);
      send_byte(8'h02); @(negedge clk);
      send_byte(8'h50);
      check("bp_busy", busy, 1);
      pulse_start();
      send_byte(8'h00); @(negedge clk);
      send_byte(8'h13); @(negedge clk);
      send_byte(8'h03); @(negedge clk);
      send_byte(8'h10); @(negedge clk);
      send_byte(8'h00);
      wait_done("bp_timeout");
      check("bp_nwr", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
         check("bp_a0", wr_addr_q[0], 0);
         check("bp_d0", wr_data_q[0], 32'h00500293);
         check("bp_a1", wr_addr_q[1], 1);
         check("bp_d1", wr_data_q[1], 32'h00100313);
      end
      check("bp_wl", words_loaded, 2);

      // N = 0: straight to DONE, no writes
      clear_log();
      pulse_start();
      send_byte(8'h00); send_byte(8'h00);
      wait_done("n0_timeout");
      check("n0_done", done, 1);
      check("n0_nwr", wr_addr_q.size(), 0);
      check("n0_wl", words_loaded, 0);

      // N = 256: fills memory exactly
      clear_log();
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      for (int i = 0; i < 256; i++) begin
         w = 32'h1000_0000 + 32'(i) * 32'd3;
         send_word(w);
      end
      wait_done("n256_timeout");
      check("n256_nwr", wr_addr_q.size(), 256);
      if (wr_addr_q.size() == 256) check("n256_last_addr", wr_addr_q[255], 255);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== 32'h1000_0000 + 32'(i) * 32'd3) bad++;
      check("n256_mem_bad", bad, 0);
      check("n256_mem255", mem[255], 32'h1000_02FD);
      check("n256_done", done, 1);
      check("n256_wl", words_loaded, 256);

      // N = 257: rejected
      clear_log();
      pulse_start();
      send_byte(8'h01); send_byte(8'h01);
      wait_done("n257_timeout");
      repeat (2) @(negedge clk);
      check("n257_err", err, 1);
      check("n257_done", done, 0);
      check("n257_cpu_rst_n", cpu_rst_n, 0);
      check("n257_ready", bus.byte_ready, 0);
      check("n257_nwr", wr_addr_q.size(), 0);

      // Reset after 5 of 8 data bytes, then a fresh full load
      clear_log();
      pulse_start();
      check("errclr_err", err, 0);
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h00500293);
      send_byte(8'h13);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_ready", bus.byte_ready, 0);
      check("mid_cpu_rst_n", cpu_rst_n, 0);
      check("mid_busy", busy, 0);
      check("mid_nwr", wr_addr_q.size(), 1);
      rst = 1'b1;
      clear_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'hDEADBEEF);
      send_word(32'h12345678);
      wait_done("mid_timeout");
      check("mid2_nwr", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) check("mid2_a0", wr_addr_q[0], 0);
      check("mid2_mem0", mem[0], 32'hDEADBEEF);
      check("mid2_mem1", mem[1], 32'h12345678);
      check("mid2_done", done, 1);

      // Reload from DONE with a one-word image
      clear_log();
      pulse_start();
      check("rl_cpu_rst_n", cpu_rst_n, 0);
      check("rl_done", done, 0);
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h44332211);
      wait_done("rl_timeout");
      check("rl_nwr", wr_addr_q.size(), 1);
      if (wr_addr_q.size() == 1) check("rl_a0", wr_addr_q[0], 0);
      check("rl_mem0", mem[0], 32'h44332211);
      check("rl_mem1", mem[1], 32'h12345678);
      check("rl_done", done, 1);
      check("rl_cpu_rst_n", cpu_rst_n, 1);
      check("rl_wl", words_loaded, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
